// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
// Shares BRAM port A (8-bit data, 15-bit address, 1-cycle registered read)
// between a CPU and a DMA master. Each transaction takes a single cycle and
// uses a req/gnt handshake. Read data returns one cycle after the grant.
// DMA can lock the port for a burst. After MAX_LOCK consecutive locked grants,
// a waiting CPU is given one slot.
//
// Build option: define BRAM_ARB_RR_EN to use round-robin arbitration in IDLE.
// The default build uses fixed priority, with CPU above DMA.
//
// Ports
//   clka, rsta_n                  clock, async active-low reset
//   cpu_req/we/addr/wdata         CPU command
//   cpu_gnt                       comb. grant (command accepted this cycle)
//   cpu_rvalid/rdata              read return, one cycle after a read grant
//   dma_* (same as cpu_*)         DMA command/return
//   dma_lock                      DMA burst lock request
//   bram_we/addr/din, bram_dout   BRAM port A pins
module bram_port_arbiter #(
   parameter int unsigned MAX_LOCK = 16,
   parameter int unsigned CNT_W    = 5
) (
   input  logic        clka,
   input  logic        rsta_n,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [14:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic        cpu_gnt,
   output logic        cpu_rvalid,
   output logic [7:0]  cpu_rdata,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [14:0] dma_addr,
   input  logic [7:0]  dma_wdata,
   output logic        dma_gnt,
   output logic        dma_rvalid,
   output logic [7:0]  dma_rdata,
   input  logic        dma_lock,
   output logic        bram_we,
   output logic [14:0] bram_addr,
   output logic [7:0]  bram_din,
   input  logic [7:0]  bram_dout
);

   typedef enum logic [1:0] {StIdle, StLock, StYield} state_t;
   typedef enum logic [1:0] {TagNone, TagCpu, TagDma} tag_t;

   localparam logic [CNT_W-1:0] LockMax = CNT_W'(MAX_LOCK);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
   tag_t             rd_tag_q, rd_tag_d;
   logic [14:0]      addr_q;
   logic [7:0]       din_q;
   logic             cpu_win, dma_win;  // IDLE arbitration result

`ifdef BRAM_ARB_RR_EN
   logic last_dma_q;  // 1: DMA took the most recent grant

   always_comb begin
      if (cpu_req && dma_req) begin
         cpu_win = last_dma_q;
         dma_win = !last_dma_q;
      end else begin
         cpu_win = cpu_req;
         dma_win = dma_req;
      end
   end

   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         last_dma_q <= 1'b0;
      end else if (cpu_gnt || dma_gnt) begin
         last_dma_q <= dma_gnt;
      end
   end
`else
   assign cpu_win = cpu_req;
   assign dma_win = dma_req && !cpu_req;
`endif

   always_comb begin
      cpu_gnt    = 1'b0;
      dma_gnt    = 1'b0;
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      case (state_q)
         StLock: begin
            if (!dma_lock || !dma_req) begin
               // Lock released: arbitrate normally in this same cycle.
               cpu_gnt    = cpu_win;
               dma_gnt    = dma_win;
               state_d    = StIdle;
               lock_cnt_d = '0;
            end else if (lock_cnt_q == LockMax) begin
               // The burst limit has been reached. Yield only if the CPU is waiting.
               if (cpu_req) begin
                  state_d = StYield;
               end else begin
                  dma_gnt = 1'b1;
               end
            end else begin
               dma_gnt    = 1'b1;
               lock_cnt_d = lock_cnt_q + 1'b1;
            end
         end
         StYield: begin
            cpu_gnt    = 1'b1;
            lock_cnt_d = '0;
            state_d    = dma_lock ? StLock : StIdle;
         end
         default: begin
            cpu_gnt = cpu_win;
            dma_gnt = dma_win;
            if (dma_win && dma_lock) begin
               state_d    = StLock;
               lock_cnt_d = CNT_W'(1);
            end
         end
      endcase
      // No grants while reset is held, even if requests are already up.
      if (!rsta_n) begin
         cpu_gnt = 1'b0;
         dma_gnt = 1'b0;
      end
   end

   always_comb begin
      bram_we   = 1'b0;
      bram_addr = addr_q;
      bram_din  = din_q;
      rd_tag_d  = TagNone;
      if (cpu_gnt) begin
         bram_we   = cpu_we;
         bram_addr = cpu_addr;
         bram_din  = cpu_wdata;
         rd_tag_d  = cpu_we ? TagNone : TagCpu;
      end else if (dma_gnt) begin
         bram_we   = dma_we;
         bram_addr = dma_addr;
         bram_din  = dma_wdata;
         rd_tag_d  = dma_we ? TagNone : TagDma;
      end
   end

   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         state_q    <= StIdle;
         lock_cnt_q <= '0;
         rd_tag_q   <= TagNone;
         addr_q     <= '0;
         din_q      <= '0;
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
         rd_tag_q   <= rd_tag_d;
         addr_q     <= bram_addr;
         din_q      <= bram_din;
      end
   end

   assign cpu_rvalid = (rd_tag_q == TagCpu);
   assign dma_rvalid = (rd_tag_q == TagDma);
   assign cpu_rdata  = cpu_rvalid ? bram_dout : 8'h00;
   assign dma_rdata  = dma_rvalid ? bram_dout : 8'h00;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter, with a behavioural BRAM model on port A.
// Inputs change 1 time unit after posedge. Outputs are checked at negedge.
module tb_bram_port_arbiter;

   logic        clka;
   logic        rsta_n;
   logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
   logic [14:0] cpu_addr;
   logic [7:0]  cpu_wdata, cpu_rdata;
   logic        dma_req, dma_we, dma_gnt, dma_rvalid, dma_lock;
   logic [14:0] dma_addr;
   logic [7:0]  dma_wdata, dma_rdata;
   logic        bram_we;
   logic [14:0] bram_addr;
   logic [7:0]  bram_din, bram_dout;

   int          pass_cnt;
   int          chk_cnt;

   logic [7:0]  mem [0:32767];

   bram_port_arbiter #(
      .MAX_LOCK(16),
      .CNT_W   (5)
   ) dut (
      .clka      (clka),
      .rsta_n    (rsta_n),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_gnt   (cpu_gnt),
      .cpu_rvalid(cpu_rvalid),
      .cpu_rdata (cpu_rdata),
      .dma_req   (dma_req),
      .dma_we    (dma_we),
      .dma_addr  (dma_addr),
      .dma_wdata (dma_wdata),
      .dma_gnt   (dma_gnt),
      .dma_rvalid(dma_rvalid),
      .dma_rdata (dma_rdata),
      .dma_lock  (dma_lock),
      .bram_we   (bram_we),
      .bram_addr (bram_addr),
      .bram_din  (bram_din),
      .bram_dout (bram_dout)
   );

   initial clka = 1'b0;
   always #5 clka = ~clka;

   always @(posedge clka) begin
      if (bram_we) mem[bram_addr] <= bram_din;
      bram_dout <= mem[bram_addr];
   end

   task automatic next_cycle();
      @(posedge clka);
      #1;
   endtask

   task automatic idle_inputs();
      cpu_req  = 1'b0;
      cpu_we   = 1'b0;
      dma_req  = 1'b0;
      dma_we   = 1'b0;
      dma_lock = 1'b0;
   endtask

   task automatic test_reset();
      rsta_n    = 1'b0;
      cpu_req   = 1'b1;
      cpu_we    = 1'b0;
      cpu_addr  = 15'h0010;
      cpu_wdata = 8'h00;
      dma_req   = 1'b1;
      dma_we    = 1'b0;
      dma_addr  = 15'h0020;
      dma_wdata = 8'h00;
      dma_lock  = 1'b0;
      @(negedge clka);
      chk_cnt++;
      if (cpu_gnt !== 1'b0) $display("FAIL reset_cpu_gnt got %b want 0", cpu_gnt);
      else pass_cnt++;
      chk_cnt++;
      if (dma_gnt !== 1'b0) $display("FAIL reset_dma_gnt got %b want 0", dma_gnt);
      else pass_cnt++;
      chk_cnt++;
      if (bram_we !== 1'b0) $display("FAIL reset_bram_we got %b want 0", bram_we);
      else pass_cnt++;
      chk_cnt++;
      if (bram_addr !== 15'h0000) $display("FAIL reset_bram_addr got %h want 0000", bram_addr);
      else pass_cnt++;
      chk_cnt++;
      if ({cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata} !== 18'h0)
         $display("FAIL reset_rvalid got %b%b %h %h want 0 0 00 00",
                  cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata);
      else pass_cnt++;
      next_cycle();
      rsta_n = 1'b1;
      @(negedge clka);
`ifdef BRAM_ARB_RR_EN
      chk_cnt++;
      if ({cpu_gnt, dma_gnt} !== 2'b01)
         $display("FAIL release_gnt got cpu=%b dma=%b want cpu=0 dma=1", cpu_gnt, dma_gnt);
      else pass_cnt++;
`else
      chk_cnt++;
      if ({cpu_gnt, dma_gnt} !== 2'b10)
         $display("FAIL release_gnt got cpu=%b dma=%b want cpu=1 dma=0", cpu_gnt, dma_gnt);
      else pass_cnt++;
`endif
      next_cycle();
      idle_inputs();
      next_cycle();
   endtask

   task automatic test_cpu_rw();
      cpu_req   = 1'b1;
      cpu_we    = 1'b1;
      cpu_addr  = 15'h0123;
      cpu_wdata = 8'h5A;
      @(negedge clka);
      chk_cnt++;
      if ({cpu_gnt, bram_we, bram_addr, bram_din} !== {1'b1, 1'b1, 15'h0123, 8'h5A})
         $display("FAIL cpu_write got gnt=%b we=%b addr=%h din=%h want 1 1 0123 5a",
                  cpu_gnt, bram_we, bram_addr, bram_din);
      else pass_cnt++;
      next_cycle();
      cpu_we = 1'b0;
      @(negedge clka);
      chk_cnt++;
      if ({cpu_gnt, bram_we, cpu_rvalid} !== 3'b100)
         $display("FAIL cpu_read_gnt got gnt=%b we=%b rvalid=%b want 1 0 0",
                  cpu_gnt, bram_we, cpu_rvalid);
      else pass_cnt++;
      next_cycle();
      cpu_req = 1'b0;
      @(negedge clka);
      chk_cnt++;
      if ({cpu_rvalid, cpu_rdata} !== {1'b1, 8'h5A})
         $display("FAIL cpu_read_data got rvalid=%b rdata=%h want 1 5a", cpu_rvalid, cpu_rdata);
      else pass_cnt++;
      chk_cnt++;
      if ({cpu_gnt, bram_we, bram_addr} !== {1'b0, 1'b0, 15'h0123})
         $display("FAIL no_grant_hold got gnt=%b we=%b addr=%h want 0 0 0123",
                  cpu_gnt, bram_we, bram_addr);
      else pass_cnt++;
      next_cycle();
      @(negedge clka);
      chk_cnt++;
      if ({cpu_rvalid, cpu_rdata} !== 9'h000)
         $display("FAIL cpu_rdata_idle got rvalid=%b rdata=%h want 0 00", cpu_rvalid, cpu_rdata);
      else pass_cnt++;
      next_cycle();
   endtask

   task automatic test_contention();
      logic [3:0] exp_cpu;
      logic [3:0] exp_dma;
`ifdef BRAM_ARB_RR_EN
      exp_cpu = 4'b1010;  // bit i = cycle i: DMA, CPU, DMA, CPU
      exp_dma = 4'b0101;
`else
      exp_cpu = 4'b1111;
      exp_dma = 4'b0000;
`endif
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 15'h0123;
      dma_req  = 1'b1;
      dma_we   = 1'b0;
      dma_addr = 15'h0200;
      dma_lock = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clka);
         chk_cnt++;
         if ({cpu_gnt, dma_gnt} !== {exp_cpu[i], exp_dma[i]})
            $display("FAIL contention_%0d got cpu=%b dma=%b want cpu=%b dma=%b",
                     i, cpu_gnt, dma_gnt, exp_cpu[i], exp_dma[i]);
         else pass_cnt++;
         if (i > 0) begin
            chk_cnt++;
            if ({cpu_rvalid, dma_rvalid} !== {exp_cpu[i-1], exp_dma[i-1]})
               $display("FAIL b2b_rvalid_%0d got cpu=%b dma=%b want cpu=%b dma=%b",
                        i, cpu_rvalid, dma_rvalid, exp_cpu[i-1], exp_dma[i-1]);
            else pass_cnt++;
         end
         next_cycle();
      end
      idle_inputs();
      next_cycle();
   endtask

   task automatic test_dma_lock_yield();
      logic exp_cpu;
      logic exp_dma;
      dma_req   = 1'b1;
      dma_we    = 1'b1;
      dma_lock  = 1'b1;
      cpu_we    = 1'b0;
      cpu_addr  = 15'h0123;
      for (int c = 0; c <= 36; c++) begin
         cpu_req   = (c >= 3);
         dma_addr  = 15'h1000 + 15'(c);
         dma_wdata = 8'(c);
         // 16 locked grants, a turnaround cycle, the CPU slot, then a new burst.
         exp_dma = (c < 16) || (c >= 18 && c < 34) || (c == 36);
         exp_cpu = (c == 17) || (c == 35);
         @(negedge clka);
         chk_cnt++;
         if ({cpu_gnt, dma_gnt} !== {exp_cpu, exp_dma})
            $display("FAIL lock_yield_c%0d got cpu=%b dma=%b want cpu=%b dma=%b",
                     c, cpu_gnt, dma_gnt, exp_cpu, exp_dma);
         else pass_cnt++;
         if (c == 16) begin
            chk_cnt++;
            if ({bram_we, bram_addr} !== {1'b0, 15'h100F})
               $display("FAIL lock_gap_bram got we=%b addr=%h want 0 100f", bram_we, bram_addr);
            else pass_cnt++;
         end
         next_cycle();
      end
      idle_inputs();
      next_cycle();
      next_cycle();
   endtask

   task automatic test_dma_lock_no_cpu();
      cpu_req  = 1'b0;
      dma_req  = 1'b1;
      dma_we   = 1'b1;
      dma_lock = 1'b1;
      for (int c = 0; c < 24; c++) begin
         dma_addr  = 15'h2000 + 15'(c);
         dma_wdata = 8'(c);
         @(negedge clka);
         chk_cnt++;
         if ({cpu_gnt, dma_gnt, bram_we} !== 3'b011)
            $display("FAIL lock_nocpu_c%0d got cpu=%b dma=%b we=%b want 0 1 1",
                     c, cpu_gnt, dma_gnt, bram_we);
         else pass_cnt++;
         next_cycle();
      end
      idle_inputs();
      next_cycle();
   endtask

   task automatic test_reset_in_flight();
      dma_req  = 1'b1;
      dma_we   = 1'b0;
      dma_lock = 1'b1;
      dma_addr = 15'h0123;
      @(negedge clka);
      chk_cnt++;
      if (dma_gnt !== 1'b1) $display("FAIL inflight_gnt got %b want 1", dma_gnt);
      else pass_cnt++;
      next_cycle();
      rsta_n = 1'b0;
      @(negedge clka);
      chk_cnt++;
      if ({dma_rvalid, dma_rdata} !== 9'h000)
         $display("FAIL inflight_drop got rvalid=%b rdata=%h want 0 00", dma_rvalid, dma_rdata);
      else pass_cnt++;
      next_cycle();
      rsta_n  = 1'b1;
      dma_req = 1'b0;
      @(negedge clka);
      chk_cnt++;
      if (dma_rvalid !== 1'b0) $display("FAIL inflight_after got %b want 0", dma_rvalid);
      else pass_cnt++;
      next_cycle();
      // A locked state would hand this cycle to DMA, while IDLE (fixed) favours the CPU.
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      dma_req  = 1'b1;
      dma_lock = 1'b1;
      @(negedge clka);
`ifdef BRAM_ARB_RR_EN
      chk_cnt++;
      if ({cpu_gnt, dma_gnt} !== 2'b01)
         $display("FAIL post_reset_idle got cpu=%b dma=%b want cpu=0 dma=1", cpu_gnt, dma_gnt);
      else pass_cnt++;
`else
      chk_cnt++;
      if ({cpu_gnt, dma_gnt} !== 2'b10)
         $display("FAIL post_reset_idle got cpu=%b dma=%b want cpu=1 dma=0", cpu_gnt, dma_gnt);
      else pass_cnt++;
`endif
      next_cycle();
      idle_inputs();
      next_cycle();
   endtask

   initial begin
      pass_cnt = 0;
      chk_cnt  = 0;
      for (int a = 0; a < 32768; a++) mem[a] = 8'h00;
      test_reset();
      test_cpu_rw();
      test_contention();
      test_dma_lock_yield();
      test_dma_lock_no_cpu();
      test_reset_in_flight();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
